// File: rtl/lin_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : lin_pkg
//  Desc    : Shared types and constants for the LIN schedule-table controller.
//  Rev     : 1.0  initial release
// ============================================================================
package lin_pkg;

    localparam int LIN_PID_W   = 6;
    localparam int LIN_LEN_W   = 4;
    localparam int LIN_MAX_LEN = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_HEADER = 3'd2,
        S_RESP   = 3'd3,
        S_IFS    = 3'd4,
        S_DONE   = 3'd5
    } sched_state_e;

    typedef struct packed {
        logic [LIN_PID_W-1:0] pid;
        logic [LIN_LEN_W-1:0] len;
    } lin_slot_t;

    // LIN responses carry at most eight data bytes.
    function automatic logic [LIN_LEN_W-1:0] sat_len(input logic [LIN_LEN_W-1:0] len);
        return (len > LIN_LEN_W'(LIN_MAX_LEN)) ? LIN_LEN_W'(LIN_MAX_LEN) : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lin_sched_table.sv
`default_nettype none
// ============================================================================
//  Module  : lin_sched_table
//  Desc    : Schedule slot register file; synchronous write, combinational read.
//  Rev     : 1.0  initial release
// ============================================================================
module lin_sched_table
    import lin_pkg::*;
#(
    parameter  int NUM_SLOTS = 8,
    localparam int AW        = $clog2(NUM_SLOTS)
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        wr_addr,
    input  logic [LIN_PID_W-1:0] wr_pid,
    input  logic [LIN_LEN_W-1:0] wr_len,
    input  logic [AW-1:0]        rd_addr,
    output lin_slot_t            rd_slot
);

    lin_slot_t r_slots [NUM_SLOTS];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slots[i] <= '0;
            end
        end else if (we) begin
            r_slots[wr_addr] <= lin_slot_t'{pid: wr_pid, len: sat_len(wr_len)};
        end
    end

    assign rd_slot = r_slots[rd_addr];

endmodule
`default_nettype wire

// File: rtl/lin_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module  : lin_frame_sched
//  Desc    : LIN schedule-table walker with inter-frame space and frame counts.
//            Define LIN_SCHED_TIMEOUT_EN to add response-timeout detection.
//  Rev     : 1.0  initial release
// ============================================================================
module lin_frame_sched
    import lin_pkg::*;
#(
    parameter  int NUM_SLOTS      = 8,
    parameter  int IFS_W          = 8,
    parameter  int CNT_W          = 16,
    parameter  int TIMEOUT_CYCLES = 2048,
    localparam int AW             = $clog2(NUM_SLOTS)
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [IFS_W-1:0]     ifs_cycles,
    input  logic                 tbl_we,
    input  logic [AW-1:0]        tbl_addr,
    input  logic [LIN_PID_W-1:0] tbl_pid,
    input  logic [LIN_LEN_W-1:0] tbl_len,
    output logic                 comm_start,
    output logic [LIN_PID_W-1:0] comm_pid,
    output logic [LIN_LEN_W-1:0] resp_len,
    input  logic                 comm_tx_done,
    input  logic                 resp_tx_done,
    output logic [AW-1:0]        slot_idx,
    output logic                 sched_busy,
    output logic                 sched_done,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 resp_timeout
);

    localparam logic [AW-1:0] c_LAST_SLOT = AW'(NUM_SLOTS - 1);

    sched_state_e         r_state;
    logic [IFS_W-1:0]     r_ifs_cnt;
    logic                 r_comm_start;
    logic [LIN_PID_W-1:0] r_comm_pid;
    logic [LIN_LEN_W-1:0] r_resp_len;
    logic [AW-1:0]        r_slot_idx;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_W-1:0]     r_frame_cnt;
    lin_slot_t            w_slot;
    logic                 w_resp_end;

    lin_sched_table #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_table (
        .sys_clk (sys_clk),
        .rst     (rst),
        .we      (tbl_we),
        .wr_addr (tbl_addr),
        .wr_pid  (tbl_pid),
        .wr_len  (tbl_len),
        .rd_addr (r_slot_idx),
        .rd_slot (w_slot)
    );

`ifdef LIN_SCHED_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              w_to_hit;

    // A response arriving on the expiry cycle wins over the timeout.
    assign w_to_hit = (r_state == S_RESP) && !resp_tx_done &&
                      (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_timeout <= w_to_hit;
            r_to_cnt  <= (r_state == S_RESP) ? r_to_cnt + c_TO_W'(1) : '0;
            if (w_to_hit && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign w_resp_end   = resp_tx_done || w_to_hit;
    assign resp_timeout = r_timeout;
    assign err_cnt      = r_err_cnt;
`else
    assign w_resp_end   = resp_tx_done;
    assign resp_timeout = 1'b0;
    assign err_cnt      = '0;
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ifs_cnt    <= '0;
            r_comm_start <= 1'b0;
            r_comm_pid   <= '0;
            r_resp_len   <= '0;
            r_slot_idx   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_comm_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_slot_idx <= '0;
                    if (en) begin
                        r_state <= S_SCAN;
                        r_busy  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (!en) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_slot_idx <= '0;
                    end else if (w_slot.len != '0) begin
                        r_comm_pid   <= w_slot.pid;
                        r_resp_len   <= w_slot.len;
                        r_comm_start <= 1'b1;
                        r_state      <= S_HEADER;
                    end else if (r_slot_idx != c_LAST_SLOT) begin
                        r_slot_idx <= r_slot_idx + AW'(1);
                    end else if (mode) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_slot_idx <= '0;
                    end
                end
                S_HEADER: begin
                    if (comm_tx_done) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_resp_end) begin
                        if (resp_tx_done) begin
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        end
                        r_ifs_cnt <= ifs_cycles;
                        r_state   <= S_IFS;
                    end
                end
                S_IFS: begin
                    // A loaded count of zero expires together with a count of one.
                    if (r_ifs_cnt < IFS_W'(2)) begin
                        if (!en) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_slot_idx <= '0;
                        end else if (r_slot_idx != c_LAST_SLOT) begin
                            r_slot_idx <= r_slot_idx + AW'(1);
                            r_state    <= S_SCAN;
                        end else if (mode) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_slot_idx <= '0;
                            r_state    <= S_SCAN;
                        end
                    end else begin
                        r_ifs_cnt <= r_ifs_cnt - IFS_W'(1);
                    end
                end
                S_DONE: begin
                    if (!en) begin
                        r_state    <= S_IDLE;
                        r_done     <= 1'b0;
                        r_slot_idx <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign comm_start = r_comm_start;
    assign comm_pid   = r_comm_pid;
    assign resp_len   = r_resp_len;
    assign slot_idx   = r_slot_idx;
    assign sched_busy = r_busy;
    assign sched_done = r_done;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire
